// File: rtl/fsm_input_stage.sv
// Input conditioning for FSM_COM: synchronizes and debounces the D/I/N buttons
// and produces the short/long timeout status from a restartable cycle counter.
module fsm_input_stage #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned T0_CYCLES = 10,
  parameter int unsigned T1_CYCLES = 20,
  parameter int unsigned CW        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       D_raw,
  input  logic       I_raw,
  input  logic       N_raw,
  input  logic       tmr_clr,
  output logic       D,
  output logic       I,
  output logic       N,
  output logic [1:0] T,
  output logic       act
);

  localparam int unsigned NCH = 3;
  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  T0_VAL  = CW'(T0_CYCLES);
  localparam logic [CW-1:0]  T1_VAL  = CW'(T1_CYCLES);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] level;
  logic [NCH-1:0] level_nxt;
  logic [DBW-1:0] cnt     [NCH];
  logic [DBW-1:0] cnt_nxt [NCH];
  logic           toggle;
  logic [CW-1:0]  tcnt;
  logic [CW-1:0]  tcnt_nxt;

  assign raw = {N_raw, I_raw, D_raw};

  // Per-channel debounce: accept s2 once it has differed for DB_CYCLES edges
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      level_nxt[ch] = level[ch];
      cnt_nxt[ch]   = '0;
      if (s2[ch] != level[ch]) begin
        if (cnt[ch] == DB_LAST) begin
          level_nxt[ch] = s2[ch];
        end else begin
          cnt_nxt[ch] = cnt[ch] + DBW'(1);
        end
      end
    end
  end

  assign toggle = |(level_nxt ^ level);

  // Timeout counter: any clear source wins, otherwise count up and saturate
  always_comb begin
    tcnt_nxt = tcnt;
    if (tmr_clr || toggle) begin
      tcnt_nxt = '0;
    end else if (tcnt < T1_VAL) begin
      tcnt_nxt = tcnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      level <= '0;
      for (int ch = 0; ch < NCH; ch++) cnt[ch] <= '0;
      tcnt  <= '0;
      T     <= 2'b00;
      act   <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      level <= level_nxt;
      for (int ch = 0; ch < NCH; ch++) cnt[ch] <= cnt_nxt[ch];
      tcnt  <= tcnt_nxt;
      T     <= {(tcnt_nxt >= T1_VAL), (tcnt_nxt >= T0_VAL)};
      act   <= toggle;
    end
  end

  assign D = level[0];
  assign I = level[1];
  assign N = level[2];

endmodule

// File: tb/tb_fsm_input_stage.sv
// Directed bench for fsm_input_stage: debounce latency, glitch rejection,
// timeout thresholds, clear priority and reset behaviour.
module tb_fsm_input_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       D_raw, I_raw, N_raw, tmr_clr;
  logic       D, I, N, act;
  logic [1:0] T;

  int vectors    = 0;
  int miscompares = 0;

  fsm_input_stage #(
    .DB_CYCLES(4), .T0_CYCLES(10), .T1_CYCLES(20), .CW(8)
  ) dut (
    .clk(clk), .reset(reset),
    .D_raw(D_raw), .I_raw(I_raw), .N_raw(N_raw), .tmr_clr(tmr_clr),
    .D(D), .I(I), .N(N), .T(T), .act(act)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; D_raw = 1'b0; I_raw = 1'b0; N_raw = 1'b0; tmr_clr = 1'b0;
    step(2);
    vectors++;
    if ({D, I, N, T, act} !== 6'b0) begin
      miscompares++; $display("FAIL reset_hold: got %b expected %b", {D, I, N, T, act}, 6'b0);
    end
    @(negedge clk); reset = 1'b0; D_raw = 1'b1;
    step(6);
    vectors++;
    if ({D, act} !== 2'b11) begin
      miscompares++; $display("FAIL pre_reset_press: got %b expected %b", {D, act}, 2'b11);
    end
    #2 reset = 1'b1;
    #1 vectors++;
    if ({D, I, N, T, act} !== 6'b0) begin
      miscompares++; $display("FAIL reset_async: got %b expected %b", {D, I, N, T, act}, 6'b0);
    end
    D_raw = 1'b0;
    @(negedge clk); reset = 1'b0;
    step(9);
    vectors++;
    if (T !== 2'b00) begin
      miscompares++; $display("FAIL reset_t_edge9: got %b expected %b", T, 2'b00);
    end
    step(1);
    vectors++;
    if (T !== 2'b01) begin
      miscompares++; $display("FAIL reset_t_edge10: got %b expected %b", T, 2'b01);
    end
  endtask

  task automatic test_clean_press();
    N_raw = 1'b1;
    step(5);
    vectors++;
    if ({N, act, T} !== 4'b0001) begin
      miscompares++; $display("FAIL press_edge5: got %b expected %b", {N, act, T}, 4'b0001);
    end
    step(1);
    vectors++;
    if ({N, act, T} !== 4'b1100) begin
      miscompares++; $display("FAIL press_edge6: got %b expected %b", {N, act, T}, 4'b1100);
    end
    step(1);
    vectors++;
    if ({N, act, T} !== 4'b1000) begin
      miscompares++; $display("FAIL press_edge7: got %b expected %b", {N, act, T}, 4'b1000);
    end
    step(8);
    vectors++;
    if ({N, act, T} !== 4'b1000) begin
      miscompares++; $display("FAIL press_edge15: got %b expected %b", {N, act, T}, 4'b1000);
    end
    step(1);
    vectors++;
    if ({N, act, T} !== 4'b1001) begin
      miscompares++; $display("FAIL press_edge16: got %b expected %b", {N, act, T}, 4'b1001);
    end
  endtask

  task automatic test_bounce();
    int acts = 0;
    logic [3:0] exp;
    D_raw = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step(1);
      exp = {(k >= 10) ? 1'b1 : 1'b0, (k == 10) ? 1'b1 : 1'b0, (k >= 10) ? 2'b00 : 2'b01};
      if (act === 1'b1) acts++;
      vectors++;
      if ({D, act, T} !== exp) begin
        miscompares++; $display("FAIL bounce_edge%0d: got %b expected %b", k, {D, act, T}, exp);
      end
      if (k == 3) D_raw = 1'b0;
      if (k == 4) D_raw = 1'b1;
    end
    vectors++;
    if (acts != 1) begin
      miscompares++; $display("FAIL bounce_act_count: got %0d expected 1", acts);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] exp;
    tmr_clr = 1'b1;
    step(1);
    tmr_clr = 1'b0;
    vectors++;
    if (T !== 2'b00) begin
      miscompares++; $display("FAIL timeout_edge0: got %b expected %b", T, 2'b00);
    end
    for (int k = 1; k <= 100; k++) begin
      step(1);
      exp = (k >= 20) ? 2'b11 : (k >= 10) ? 2'b01 : 2'b00;
      vectors++;
      if (T !== exp) begin
        miscompares++; $display("FAIL timeout_edge%0d: got %b expected %b", k, T, exp);
      end
    end
  endtask

  task automatic test_clear_priority();
    tmr_clr = 1'b1;
    step(1);
    tmr_clr = 1'b0;
    step(19);
    vectors++;
    if (T !== 2'b01) begin
      miscompares++; $display("FAIL clrpri_edge19: got %b expected %b", T, 2'b01);
    end
    tmr_clr = 1'b1;
    step(1);
    vectors++;
    if (T !== 2'b00) begin
      miscompares++; $display("FAIL clrpri_edge20: got %b expected %b", T, 2'b00);
    end
    for (int k = 1; k <= 30; k++) begin
      step(1);
      vectors++;
      if (T !== 2'b00) begin
        miscompares++; $display("FAIL clrpri_hold%0d: got %b expected %b", k, T, 2'b00);
      end
    end
    tmr_clr = 1'b0;
    step(9);
    vectors++;
    if (T !== 2'b00) begin
      miscompares++; $display("FAIL clrpri_rel9: got %b expected %b", T, 2'b00);
    end
    step(1);
    vectors++;
    if (T !== 2'b01) begin
      miscompares++; $display("FAIL clrpri_rel10: got %b expected %b", T, 2'b01);
    end
  endtask

  task automatic test_simultaneous();
    int acts = 0;
    logic [2:0] exp3;
    logic [4:0] exp5;
    D_raw = 1'b0; N_raw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      exp3 = (k < 6) ? 3'b110 : (k == 6) ? 3'b001 : 3'b000;
      vectors++;
      if ({D, N, act} !== exp3) begin
        miscompares++; $display("FAIL fall_edge%0d: got %b expected %b", k, {D, N, act}, exp3);
      end
    end
    D_raw = 1'b1; I_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      exp5 = (k < 6) ? 5'b00000 : (k == 6) ? 5'b11100 : 5'b11000;
      if (act === 1'b1) acts++;
      vectors++;
      if ({D, I, act, T} !== exp5) begin
        miscompares++; $display("FAIL simul_edge%0d: got %b expected %b", k, {D, I, act, T}, exp5);
      end
    end
    vectors++;
    if (acts != 1) begin
      miscompares++; $display("FAIL simul_act_count: got %0d expected 1", acts);
    end
  endtask

  task automatic test_reset_abort();
    logic [3:0] exp;
    N_raw = 1'b1;
    step(4);
    reset = 1'b1;
    #1 vectors++;
    if ({D, I, N, T, act} !== 6'b0) begin
      miscompares++; $display("FAIL abort_reset: got %b expected %b", {D, I, N, T, act}, 6'b0);
    end
    @(negedge clk); reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      exp = (k < 6) ? 4'b0000 : 4'b1111;
      vectors++;
      if ({D, I, N, act} !== exp) begin
        miscompares++; $display("FAIL abort_edge%0d: got %b expected %b", k, {D, I, N, act}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_timeout();
    test_clear_priority();
    test_simultaneous();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
